// File: rtl/ofdm_sync_pkg.sv
// Shared types and register map for the OFDM detector sync controller.
package ofdm_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLEARING = 2'd1,
        ST_ARMED    = 2'd2,
        ST_HOLDOFF  = 2'd3
    } sync_state_e;

    localparam logic [2:0] ADDR_THRESHOLD = 3'd0;
    localparam logic [2:0] ADDR_PKT_LEN   = 3'd1;
    localparam logic [2:0] ADDR_OUT_SEL   = 3'd2;
    localparam logic [2:0] ADDR_CONTROL   = 3'd3;
    localparam logic [2:0] ADDR_TIMEOUT   = 3'd4;

    function automatic logic cfg_hit(input logic wr_en, input logic [2:0] addr,
                                     input logic [2:0] target);
        return wr_en && (addr == target);
    endfunction

endpackage

// File: rtl/ofdm_sync_controller_counter.sv
// Counts accepted samples while armed and flags the strobe that reaches the limit.
module sample_timeout_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        strobe,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Next count: start wins over a coincident strobe.
    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = 32'd0;
        end else if (strobe) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // A limit of zero disables expiry.
    assign expired = strobe && !start && (limit != 32'd0) && ((count_q + 32'd1) == limit);

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ofdm_sync_controller.sv
// Sequences detector clears, arms for a frame, and applies holdoff/timeout policy.
module ofdm_sync_controller
    import ofdm_sync_pkg::*;
#(
    parameter int CLEAR_CYCLES   = 2,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_wr_en,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wr_data,
    input  logic        sample_strobe,
    input  logic        end_of_ofdm_packet,
    output logic [31:0] det_threshold,
    output logic [31:0] det_packet_length,
    output logic [1:0]  det_output_select,
    output logic        det_clear,
    output logic        busy,
    output logic [31:0] frame_count,
    output logic [15:0] timeout_count
);

    localparam logic [31:0] CLR_LAST  = 32'(CLEAR_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);

    sync_state_e state_q, state_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] thr_sh_q, len_sh_q, timeout_q;
    logic [1:0]  sel_sh_q;
    logic        enable_q, enable_d, single_shot_q;
    logic [31:0] det_thr_q, det_len_q, frame_q, frame_d;
    logic [1:0]  det_sel_q;
    logic        det_clear_q, busy_q;
    logic [15:0] tmo_q, tmo_d;
    logic        arm_start_s, fsm_disable_s, enter_clear_s, expired_s, armed_strobe_s;

    assign armed_strobe_s = sample_strobe && (state_q == ST_ARMED);

    sample_timeout_counter u_counter (
        .clk     (clk),
        .reset   (reset),
        .start   (arm_start_s),
        .strobe  (armed_strobe_s),
        .limit   (timeout_q),
        .expired (expired_s)
    );

    // Next-state logic; abort outranks frame end, which outranks timeout.
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        frame_d       = frame_q;
        tmo_d         = tmo_q;
        arm_start_s   = 1'b0;
        fsm_disable_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_q) begin
                    state_d = ST_CLEARING;
                    cyc_d   = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEARING: begin
                if (cyc_q == CLR_LAST) begin
                    cyc_d = 32'd0;
                    if (enable_q) begin
                        state_d     = ST_ARMED;
                        arm_start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            ST_ARMED: begin
                if (!enable_q) begin
                    state_d = ST_CLEARING;
                    cyc_d   = 32'd0;
                end else if (end_of_ofdm_packet) begin
                    state_d = ST_HOLDOFF;
                    cyc_d   = 32'd0;
                    frame_d = frame_q + 32'd1;
                end else if (expired_s) begin
                    state_d = ST_CLEARING;
                    cyc_d   = 32'd0;
                    tmo_d   = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_HOLDOFF: begin
                if (cyc_q == HOLD_LAST) begin
                    cyc_d         = 32'd0;
                    fsm_disable_s = single_shot_q;
                    if (enable_q && !single_shot_q) begin
                        state_d = ST_CLEARING;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 32'd0;
            end
        endcase
    end

    assign enter_clear_s = (state_d == ST_CLEARING) && (state_q != ST_CLEARING);

    // A software control write overrides the single-shot auto-disable.
    always_comb begin
        if (cfg_hit(cfg_wr_en, cfg_addr, ADDR_CONTROL)) begin
            enable_d = cfg_wr_data[0];
        end else if (fsm_disable_s) begin
            enable_d = 1'b0;
        end else begin
            enable_d = enable_q;
        end
    end

    // Configuration shadows and control register.
    always_ff @(posedge clk) begin
        if (reset) begin
            thr_sh_q      <= 32'hFFFF_FFFF;
            len_sh_q      <= 32'd0;
            sel_sh_q      <= 2'd0;
            timeout_q     <= 32'd0;
            enable_q      <= 1'b0;
            single_shot_q <= 1'b0;
        end else begin
            enable_q <= enable_d;
            if (cfg_hit(cfg_wr_en, cfg_addr, ADDR_THRESHOLD)) thr_sh_q <= cfg_wr_data;
            if (cfg_hit(cfg_wr_en, cfg_addr, ADDR_PKT_LEN))   len_sh_q <= cfg_wr_data;
            if (cfg_hit(cfg_wr_en, cfg_addr, ADDR_OUT_SEL))   sel_sh_q <= cfg_wr_data[1:0];
            if (cfg_hit(cfg_wr_en, cfg_addr, ADDR_CONTROL))   single_shot_q <= cfg_wr_data[1];
            if (cfg_hit(cfg_wr_en, cfg_addr, ADDR_TIMEOUT))   timeout_q <= cfg_wr_data;
        end
    end

    // FSM state, statistics and registered detector-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 32'd0;
            det_thr_q   <= 32'hFFFF_FFFF;
            det_len_q   <= 32'd0;
            det_sel_q   <= 2'd0;
            det_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_q     <= 32'd0;
            tmo_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            det_clear_q <= (state_d == ST_CLEARING);
            busy_q      <= (state_d != ST_IDLE);
            frame_q     <= frame_d;
            tmo_q       <= tmo_d;
            if (enter_clear_s) begin
                det_thr_q <= thr_sh_q;
                det_len_q <= len_sh_q;
                det_sel_q <= sel_sh_q;
            end
        end
    end

    assign det_threshold     = det_thr_q;
    assign det_packet_length = det_len_q;
    assign det_output_select = det_sel_q;
    assign det_clear         = det_clear_q;
    assign busy              = busy_q;
    assign frame_count       = frame_q;
    assign timeout_count     = tmo_q;

endmodule

// File: tb/tb_ofdm_sync_controller.sv
// Directed scoreboard bench for ofdm_sync_controller with default parameters.
module tb_ofdm_sync_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_wr_data = 32'd0;
    logic        sample_strobe = 1'b0;
    logic        end_of_ofdm_packet = 1'b0;
    logic [31:0] det_threshold, det_packet_length, frame_count;
    logic [1:0]  det_output_select;
    logic        det_clear, busy;
    logic [15:0] timeout_count;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ofdm_sync_controller dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_addr           (cfg_addr),
        .cfg_wr_data        (cfg_wr_data),
        .sample_strobe      (sample_strobe),
        .end_of_ofdm_packet (end_of_ofdm_packet),
        .det_threshold      (det_threshold),
        .det_packet_length  (det_packet_length),
        .det_output_select  (det_output_select),
        .det_clear          (det_clear),
        .busy               (busy),
        .frame_count        (frame_count),
        .timeout_count      (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wr_data = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        reset = 1'b0;
        push("rst_thr", 32'hFFFF_FFFF); push("rst_len", 32'd0); push("rst_sel", 32'd0);
        push("rst_clear", 32'd0); push("rst_busy", 32'd0); push("rst_frames", 32'd0);
        push("rst_tmo", 32'd0);
        pop_chk(det_threshold); pop_chk(det_packet_length); pop_chk(32'(det_output_select));
        pop_chk(32'(det_clear)); pop_chk(32'(busy)); pop_chk(frame_count); pop_chk(32'(timeout_count));

        // Shadows only, then enable: outputs follow on CLEARING entry
        wr(3'd0, 32'd1000); wr(3'd1, 32'd640); wr(3'd2, 32'd1);
        push("shadow_no_direct", 32'hFFFF_FFFF);
        pop_chk(det_threshold);
        wr(3'd3, 32'd1);
        push("idle_before_clear", 32'd0);
        pop_chk(32'(det_clear));
        tick();
        push("clr1", 32'd1); push("thr_loaded", 32'd1000); push("len_loaded", 32'd640);
        push("sel_loaded", 32'd1); push("busy_clearing", 32'd1);
        pop_chk(32'(det_clear)); pop_chk(det_threshold); pop_chk(det_packet_length);
        pop_chk(32'(det_output_select)); pop_chk(32'(busy));
        tick();
        push("clr2", 32'd1);
        pop_chk(32'(det_clear));
        tick();
        push("armed_clear_low", 32'd0); push("armed_busy", 32'd1);
        pop_chk(32'(det_clear)); pop_chk(32'(busy));

        // Frame end -> holdoff (stray end pulse ignored) -> re-clear -> armed
        end_of_ofdm_packet = 1'b1;
        tick();
        push("frame1", 32'd1);
        pop_chk(frame_count);
        for (int i = 0; i < 15; i++) begin
            end_of_ofdm_packet = (i == 0);
            tick();
        end
        end_of_ofdm_packet = 1'b0;
        push("holdoff_no_clear", 32'd0); push("eop_in_holdoff_ignored", 32'd1);
        pop_chk(32'(det_clear)); pop_chk(frame_count);
        tick();
        push("reclear1", 32'd1);
        pop_chk(32'(det_clear));
        tick();
        push("reclear2", 32'd1);
        pop_chk(32'(det_clear));
        tick();
        push("rearmed", 32'd0);
        pop_chk(32'(det_clear));

        // Timeout of 100 strobes
        wr(3'd4, 32'd100);
        sample_strobe = 1'b1;
        tick(99);
        push("no_timeout_99", 32'd0);
        pop_chk(32'(det_clear));
        tick();
        sample_strobe = 1'b0;
        push("timeout_clear", 32'd1); push("tmo1", 32'd1); push("frames_kept", 32'd1);
        pop_chk(32'(det_clear)); pop_chk(32'(timeout_count)); pop_chk(frame_count);
        tick(2);
        push("rearmed_after_tmo", 32'd0);
        pop_chk(32'(det_clear));

        // Frame end and expiry together count as a frame only
        sample_strobe = 1'b1;
        tick(99);
        end_of_ofdm_packet = 1'b1;
        tick();
        sample_strobe = 1'b0; end_of_ofdm_packet = 1'b0;
        push("tie_frame", 32'd2); push("tie_tmo", 32'd1); push("tie_holdoff", 32'd0);
        pop_chk(frame_count); pop_chk(32'(timeout_count)); pop_chk(32'(det_clear));
        tick(16);
        push("tie_reclear", 32'd1);
        pop_chk(32'(det_clear));
        tick(2);

        // Single-shot: holdoff ends in IDLE and stays there
        wr(3'd3, 32'd3);
        end_of_ofdm_packet = 1'b1;
        tick();
        end_of_ofdm_packet = 1'b0;
        push("ss_frame", 32'd3);
        pop_chk(frame_count);
        tick(16);
        push("ss_idle_busy", 32'd0); push("ss_idle_clear", 32'd0);
        pop_chk(32'(busy)); pop_chk(32'(det_clear));
        tick(3);
        push("ss_stays_idle_busy", 32'd0); push("ss_stays_idle_clear", 32'd0);
        pop_chk(32'(busy)); pop_chk(32'(det_clear));

        // Shadow write while armed, then abort
        wr(3'd3, 32'd1);
        tick(3);
        wr(3'd0, 32'd5);
        tick(3);
        push("thr_held_armed", 32'd1000);
        pop_chk(det_threshold);
        wr(3'd3, 32'd0);
        tick();
        push("abort_clear1", 32'd1); push("abort_thr_loaded", 32'd5);
        pop_chk(32'(det_clear)); pop_chk(det_threshold);
        tick();
        push("abort_clear2", 32'd1);
        pop_chk(32'(det_clear));
        tick();
        push("abort_idle_clear", 32'd0); push("abort_idle_busy", 32'd0);
        push("abort_frames", 32'd3); push("abort_tmo", 32'd1);
        pop_chk(32'(det_clear)); pop_chk(32'(busy)); pop_chk(frame_count); pop_chk(32'(timeout_count));

        // Control write on the single-shot disable edge wins
        wr(3'd3, 32'd3);
        tick(3);
        end_of_ofdm_packet = 1'b1;
        tick();
        end_of_ofdm_packet = 1'b0;
        tick(15);
        wr(3'd3, 32'd1);
        push("race_exit_idle", 32'd0);
        pop_chk(32'(busy));
        tick();
        push("race_write_wins", 32'd1);
        pop_chk(32'(det_clear));

        // Reset in the middle of CLEARING
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push("mid_rst_clear", 32'd0); push("mid_rst_busy", 32'd0);
        push("mid_rst_thr", 32'hFFFF_FFFF); push("mid_rst_frames", 32'd0); push("mid_rst_tmo", 32'd0);
        pop_chk(32'(det_clear)); pop_chk(32'(busy)); pop_chk(det_threshold);
        pop_chk(frame_count); pop_chk(32'(timeout_count));
        tick(2);
        push("post_rst_idle", 32'd0);
        pop_chk(32'(det_clear));

        if (sb_q.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
